// File: rtl/dmem_responder_if.sv
// Request/response bus between a memory initiator and dmem_responder.
// The initiator drives the master modport; the responder sits on slave.
interface dmem_responder_if #(
  parameter int DATA_WID = 64
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [DATA_WID-1:0] req_addr;
  logic [DATA_WID-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_WID-1:0] resp_rdata;
  logic                resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder: accept, wait LATENCY edges,
// commit to word storage, then hold the response until the initiator takes it.
module dmem_responder #(
  parameter int DATA_WID  = 64,
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input logic               CLK,
  input logic               RST,
  dmem_responder_if.slave   bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]     CNT_LOAD = CW'(LATENCY - 1);
  // One extra bit so the byte limit never wraps for small DATA_WID.
  localparam logic [DATA_WID:0] LIMIT    = (DATA_WID + 1)'(MEM_WORDS * 8);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]       cnt;
  logic                lat_write;
  logic [DATA_WID-1:0] lat_addr;
  logic [DATA_WID-1:0] lat_wdata;
  logic                lat_err;
  logic [AW-1:0]       widx;
  logic                accept;
  logic                commit;
  logic                handshake;

  logic [DATA_WID-1:0] mem [MEM_WORDS];

  assign lat_err = (lat_addr[2:0] != 3'b000) || ({1'b0, lat_addr} >= LIMIT);
  assign widx    = lat_addr[AW+2:3];

  assign bus.req_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        accept    = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (cnt == '0) begin
        commit    = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (bus.resp_ready) begin
        handshake = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_write      <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        cnt       <= CNT_LOAD;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        bus.resp_valid <= 1'b1;
        bus.resp_error <= lat_err;
        bus.resp_rdata <= (lat_err || lat_write) ? '0 : mem[widx];
      end else if (handshake) begin
        bus.resp_valid <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; an aborted transaction never reaches
  // commit because reset forces IDLE asynchronously.
  always_ff @(posedge CLK) begin
    if (commit && lat_write && !lat_err)
      mem[widx] <= lat_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a transaction-level memory model,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_responder;
  localparam int L  = 2;
  localparam int MW = 256;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  dmem_responder_if #(.DATA_WID(64)) b ();

  dmem_responder #(.DATA_WID(64), .MEM_WORDS(MW), .LATENCY(L)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (b)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one outstanding request, response visible
  // L edges after acceptance, retired by the first edge with resp_ready.
  bit              m_busy = 0;
  int              m_age  = 0;
  bit              m_wr;
  logic [63:0]     m_addr, m_wd, m_rd;
  bit              m_err, m_known;
  logic [63:0]     mmem [longint unsigned];

  always @(posedge CLK) begin
    if (RST) m_busy = 0;
    else if (!m_busy) begin
      if (b.req_valid) begin
        m_busy = 1; m_age = 0;
        m_wr = b.req_write; m_addr = b.req_addr; m_wd = b.req_wdata;
      end
    end else if (m_age < L) begin
      m_age++;
      if (m_age == L) begin
        m_err   = (m_addr % 8 != 0) || (m_addr >= 64'(MW * 8));
        m_known = 1;
        m_rd    = 64'h0;
        if (!m_err) begin
          if (m_wr) mmem[m_addr / 8] = m_wd;
          else if (mmem.exists(m_addr / 8)) m_rd = mmem[m_addr / 8];
          else m_known = 0;
        end
      end
    end else if (b.resp_ready) m_busy = 0;
  end

  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_req_ready", 64'(b.req_ready), 64'd1);
      chk("rst_resp_valid", 64'(b.resp_valid), 64'd0);
      chk("rst_resp_rdata", b.resp_rdata, 64'd0);
      chk("rst_resp_error", 64'(b.resp_error), 64'd0);
    end else begin
      chk("req_ready", 64'(b.req_ready), 64'(!m_busy));
      chk("resp_valid", 64'(b.resp_valid), 64'(m_busy && m_age == L));
      if (m_busy && m_age == L) begin
        chk("resp_error", 64'(b.resp_error), 64'(m_err));
        if (m_known) chk("resp_rdata", b.resp_rdata, m_rd);
      end
    end
  end

  task automatic txn(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                     input int hold, output logic [63:0] rd, output logic er,
                     output int lat);
    int n, c0;
    rd = '0; er = 1'b0; lat = -1;
    @(negedge CLK);
    b.req_valid = 1'b1; b.req_write = wr; b.req_addr = a; b.req_wdata = wd;
    b.resp_ready = 1'b0;
    n = 0;
    while (!b.req_ready && n < 20) begin @(negedge CLK); n++; end
    if (!b.req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1); b.req_valid = 1'b0; return;
    end
    c0 = cyc;
    @(negedge CLK);
    // Scramble inputs after accept; the latched request must be unaffected.
    b.req_valid = 1'b0; b.req_write = 1'($urandom);
    b.req_addr = {$urandom, $urandom}; b.req_wdata = {$urandom, $urandom};
    n = 0;
    while (!b.resp_valid && n < 20) begin @(negedge CLK); n++; end
    if (!b.resp_valid) begin chk("resp_timeout", 64'd0, 64'd1); return; end
    lat = cyc - c0 - 1;
    rd = b.resp_rdata; er = b.resp_error;
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("hold_valid", 64'(b.resp_valid), 64'd1);
      chk("hold_rdata", b.resp_rdata, rd);
      chk("hold_error", 64'(b.resp_error), 64'(er));
      chk("hold_req_ready", 64'(b.req_ready), 64'd0);
    end
    b.resp_ready = 1'b1;
    @(negedge CLK);
    b.resp_ready = 1'b0;
    chk("post_hs_req_ready", 64'(b.req_ready), 64'd1);
    chk("post_hs_valid", 64'(b.resp_valid), 64'd0);
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(9))
      6:       return 64'($urandom_range(15)) * 8 + 64'($urandom_range(7, 1));
      7:       return 64'h800;
      8:       return 64'h1_0000_0000 | (64'($urandom_range(15)) * 8);
      9:       return 64'h7F8;
      default: return 64'($urandom_range(15)) * 8;
    endcase
  endfunction

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat, n;
    int          acc [3];
    logic [63:0] ra  [3];

    b.req_valid = 1'b0; b.req_write = 1'b0; b.req_addr = '0; b.req_wdata = '0;
    b.resp_ready = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    chk("first_cycle_ready", 64'(b.req_ready), 64'd1);

    txn(1, 64'h10, 64'h1122334455667788, 0, rd, er, lat);
    chk("wr10_latency", 64'(lat), 64'd2);
    chk("wr10_error", 64'(er), 64'd0);
    chk("wr10_rdata", rd, 64'd0);

    txn(0, 64'h10, 64'h0, 5, rd, er, lat);
    chk("rd10_rdata", rd, 64'h1122334455667788);
    chk("rd10_error", 64'(er), 64'd0);

    txn(0, 64'h13, 64'h0, 0, rd, er, lat);
    chk("rd13_error", 64'(er), 64'd1);
    chk("rd13_rdata", rd, 64'd0);
    txn(0, 64'h800, 64'h0, 0, rd, er, lat);
    chk("rd800_error", 64'(er), 64'd1);
    chk("rd800_rdata", rd, 64'd0);

    txn(1, 64'h0, 64'hCAFE_F00D_0000_0001, 0, rd, er, lat);
    txn(1, 64'h800, 64'hDEAD_BEEF_DEAD_BEEF, 0, rd, er, lat);
    chk("wr800_error", 64'(er), 64'd1);
    txn(1, 64'h1_0000_0000, 64'h0BAD_0BAD_0BAD_0BAD, 0, rd, er, lat);
    chk("wr_wrap_error", 64'(er), 64'd1);
    txn(0, 64'h0, 64'h0, 0, rd, er, lat);
    chk("rd0_unchanged", rd, 64'hCAFE_F00D_0000_0001);

    // Reset in BUSY with the counter at zero must abort the pending write.
    txn(1, 64'h20, 64'h5555, 0, rd, er, lat);
    @(negedge CLK);
    b.req_valid = 1'b1; b.req_write = 1'b1; b.req_addr = 64'h20; b.req_wdata = 64'hAA;
    @(negedge CLK);
    b.req_valid = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b1;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_ready", 64'(b.req_ready), 64'd1);
    chk("post_rst_valid", 64'(b.resp_valid), 64'd0);
    txn(0, 64'h20, 64'h0, 0, rd, er, lat);
    chk("rd20_pre_reset", rd, 64'h5555);

    // Back-to-back reads with req_valid held high.
    ra[0] = 64'h10; ra[1] = 64'h20; ra[2] = 64'h0;
    @(negedge CLK);
    b.resp_ready = 1'b1; b.req_valid = 1'b1; b.req_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b.req_addr = ra[k];
      n = 0;
      while (!b.req_ready && n < 20) begin @(negedge CLK); n++; end
      if (!b.req_ready) chk("b2b_timeout", 64'd0, 64'd1);
      acc[k] = cyc;
      @(negedge CLK);
    end
    b.req_valid = 1'b0;
    repeat (6) @(negedge CLK);
    b.resp_ready = 1'b0;
    chk("b2b_spacing01", 64'(acc[1] - acc[0]), 64'(L + 2));
    chk("b2b_spacing12", 64'(acc[2] - acc[1]), 64'(L + 2));

    for (int i = 0; i < 16; i++) txn(1, 64'(i * 8), {$urandom, $urandom}, 0, rd, er, lat);
    for (int i = 0; i < 150; i++) begin
      txn(1'($urandom), pick_addr(), {$urandom, $urandom}, $urandom_range(3), rd, er, lat);
      repeat ($urandom_range(2)) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
